// File: rtl/rx_iq_frame_packer.sv
// Purpose : gathers one 24-bit I/Q pair per DDC channel into a frame and serialises it as 16-bit words.
// Latency : rx_avail_A pulses 1 cycle after the strobe that completes a frame; rx_din_A is combinational.
// Backpressure: none upstream; a frame finishing while the read bank is still busy is dropped and counted.
//
// Ports:
//   adc_clk, reset          clock and asynchronous active-high reset
//   samp_avail/i_data/q_data per-channel capture strobe and 24-bit two's complement I/Q samples
//   rd_word                 consumer takes rx_din_A and advances to the next word
//   clear_err               clears overrun/dup_err/underrun/drop_cnt
//   rx_din_A, chan_o        current word and its channel index
//   rx_avail_A, rd_busy     new-frame pulse and read-bank-occupied flag
//   overrun, dup_err, underrun, drop_cnt  sticky error flags and saturating drop counter
module rx_iq_frame_packer #(
    parameter int NCHAN  = 4,
    parameter int DROP_W = 8
) (
    input  logic                  adc_clk,
    input  logic                  reset,
    input  logic [NCHAN-1:0]      samp_avail,
    input  logic [NCHAN*24-1:0]   i_data,
    input  logic [NCHAN*24-1:0]   q_data,
    input  logic                  rd_word,
    input  logic                  clear_err,
    output logic [15:0]           rx_din_A,
    output logic                  rx_avail_A,
    output logic                  rd_busy,
    output logic [3:0]            chan_o,
    output logic                  overrun,
    output logic                  dup_err,
    output logic                  underrun,
    output logic [DROP_W-1:0]     drop_cnt
);

    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    // Each entry holds {I[23:0], Q[23:0]}. bank[rd_sel] is the read bank,
    // bank[~rd_sel] is being filled by capture.
    logic [47:0]      bank [2][NCHAN];
    logic             rd_sel;
    logic [NCHAN-1:0] got;
    logic [CW-1:0]    ch;
    logic [1:0]       wsel;

    logic        advance;
    logic        last_word;
    logic        release_rd;
    logic        frame_done;
    logic        busy_post;
    logic        swap;
    logic        drop;
    logic        dup_ev;
    logic        und_ev;
    logic [47:0] rd_entry;

    always_comb begin
        advance    = rd_word && rd_busy;
        last_word  = (wsel == 2'd2) && (ch == CW'(NCHAN - 1));
        release_rd = advance && last_word;
        frame_done = &(got | samp_avail);
        // A release in this same cycle frees the read bank in time for the swap.
        busy_post  = rd_busy && !release_rd;
        swap       = frame_done && !busy_post;
        drop       = frame_done && busy_post;
        dup_ev     = |(got & samp_avail);
        und_ev     = rd_word && !rd_busy;
    end

    assign rd_entry = bank[rd_sel][ch];
    assign chan_o   = 4'(ch);

    always_comb begin
        rx_din_A = 16'h0000;
        case (wsel)
            2'd0:    rx_din_A = rd_entry[47:32];                   // I[23:8]
            2'd1:    rx_din_A = rd_entry[23:8];                    // Q[23:8]
            default: rx_din_A = {rd_entry[31:24], rd_entry[7:0]};  // {I[7:0], Q[7:0]}
        endcase
    end

    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NCHAN; c++) begin
                    bank[b][c] <= '0;
                end
            end
            rd_sel     <= 1'b0;
            got        <= '0;
            ch         <= '0;
            wsel       <= 2'd0;
            rd_busy    <= 1'b0;
            rx_avail_A <= 1'b0;
            overrun    <= 1'b0;
            dup_err    <= 1'b0;
            underrun   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            // Capture into the write bank; the bank index uses the pre-swap rd_sel,
            // so the completing strobe lands in the bank that becomes readable.
            for (int c = 0; c < NCHAN; c++) begin
                if (samp_avail[c]) begin
                    bank[~rd_sel][c] <= {i_data[24*c+23 -: 24], q_data[24*c+23 -: 24]};
                end
            end

            if (frame_done) begin
                got <= '0;
            end else begin
                got <= got | samp_avail;
            end

            if (advance) begin
                if (wsel != 2'd2) begin
                    wsel <= wsel + 2'd1;
                end else begin
                    wsel <= 2'd0;
                    ch   <= last_word ? '0 : ch + CW'(1);
                end
            end

            if (swap) begin
                rd_sel  <= ~rd_sel;
                rd_busy <= 1'b1;
            end else if (release_rd) begin
                rd_busy <= 1'b0;
            end
            rx_avail_A <= swap;

            // An error event in the clear cycle leaves its flag set.
            overrun  <= (overrun  && !clear_err) || drop;
            dup_err  <= (dup_err  && !clear_err) || dup_ev;
            underrun <= (underrun && !clear_err) || und_ev;

            if (drop) begin
                if (clear_err) begin
                    drop_cnt <= DROP_W'(1);
                end else if (!(&drop_cnt)) begin
                    drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end else if (clear_err) begin
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx_iq_frame_packer.sv
// Purpose : directed test of rx_iq_frame_packer against a frame-level behavioural model.
// Latency : model predicts outputs per cycle; compared on every falling edge.
// Backpressure: bench drives rd_word directly; no flow control in the harness.
module tb_rx_iq_frame_packer;

    localparam int NCHAN  = 4;
    localparam int DROP_W = 8;
    localparam int NW     = 3 * NCHAN;

    logic                adc_clk = 1'b0;
    logic                reset   = 1'b1;
    logic [NCHAN-1:0]    samp_avail = '0;
    logic [NCHAN*24-1:0] i_data = '0;
    logic [NCHAN*24-1:0] q_data = '0;
    logic                rd_word = 1'b0;
    logic                clear_err = 1'b0;
    logic [15:0]         rx_din_A;
    logic                rx_avail_A;
    logic                rd_busy;
    logic [3:0]          chan_o;
    logic                overrun;
    logic                dup_err;
    logic                underrun;
    logic [DROP_W-1:0]   drop_cnt;

    rx_iq_frame_packer #(.NCHAN(NCHAN), .DROP_W(DROP_W)) dut (
        .adc_clk    (adc_clk),
        .reset      (reset),
        .samp_avail (samp_avail),
        .i_data     (i_data),
        .q_data     (q_data),
        .rd_word    (rd_word),
        .clear_err  (clear_err),
        .rx_din_A   (rx_din_A),
        .rx_avail_A (rx_avail_A),
        .rd_busy    (rd_busy),
        .chan_o     (chan_o),
        .overrun    (overrun),
        .dup_err    (dup_err),
        .underrun   (underrun),
        .drop_cnt   (drop_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (frame = list of words) ----------------
    bit [23:0] m_i [NCHAN];
    bit [23:0] m_q [NCHAN];
    bit        m_got [NCHAN];
    bit [15:0] m_frame [NW];
    int        m_idx;
    bit        m_busy, m_avail, m_ov, m_dup, m_und;
    int        m_drop;

    task automatic model_reset();
        for (int c = 0; c < NCHAN; c++) begin
            m_i[c] = '0; m_q[c] = '0; m_got[c] = 0;
        end
        for (int w = 0; w < NW; w++) m_frame[w] = '0;
        m_idx = 0; m_busy = 0; m_avail = 0; m_ov = 0; m_dup = 0; m_und = 0; m_drop = 0;
    endtask

    task automatic model_step();
        bit busy0, done, drop_ev, swap_ev, dup_ev, und_ev;
        int base;
        busy0 = m_busy; drop_ev = 0; swap_ev = 0; dup_ev = 0;
        und_ev = rd_word && !busy0;
        if (rd_word && busy0) begin
            if (m_idx == NW - 1) begin
                m_busy = 0; m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        done = 1;
        for (int c = 0; c < NCHAN; c++) if (!(m_got[c] || samp_avail[c])) done = 0;
        for (int c = 0; c < NCHAN; c++) begin
            if (samp_avail[c]) begin
                if (m_got[c]) dup_ev = 1;
                m_i[c] = i_data[24*c +: 24];
                m_q[c] = q_data[24*c +: 24];
                m_got[c] = 1;
            end
        end
        if (done) begin
            for (int c = 0; c < NCHAN; c++) m_got[c] = 0;
            if (m_busy) begin
                drop_ev = 1;
            end else begin
                swap_ev = 1;
                for (int c = 0; c < NCHAN; c++) begin
                    m_frame[3*c]   = m_i[c][23:8];
                    m_frame[3*c+1] = m_q[c][23:8];
                    m_frame[3*c+2] = {m_i[c][7:0], m_q[c][7:0]};
                end
                m_busy = 1; m_idx = 0;
            end
        end
        m_avail = swap_ev;
        m_ov  = (m_ov  && !clear_err) || drop_ev;
        m_dup = (m_dup && !clear_err) || dup_ev;
        m_und = (m_und && !clear_err) || und_ev;
        base = clear_err ? 0 : m_drop;
        if (drop_ev && base < 255) base++;
        m_drop = base;
    endtask

    initial begin
        forever begin
            @(posedge adc_clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge adc_clk);
            check("cmp_din",   rx_din_A,   m_frame[m_idx]);
            check("cmp_chan",  chan_o,     m_idx / 3);
            check("cmp_avail", rx_avail_A, m_avail);
            check("cmp_busy",  rd_busy,    m_busy);
            check("cmp_ovr",   overrun,    m_ov);
            check("cmp_dup",   dup_err,    m_dup);
            check("cmp_und",   underrun,   m_und);
            check("cmp_drop",  drop_cnt,   m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic set_chan(input int c, input logic [23:0] iv, input logic [23:0] qv);
        i_data[24*c +: 24] = iv;
        q_data[24*c +: 24] = qv;
    endtask

    task automatic strobe(input logic [NCHAN-1:0] m);
        samp_avail = m;
        tick();
        samp_avail = '0;
    endtask

    task automatic do_reads(input int n);
        for (int k = 0; k < n; k++) begin
            rd_word = 1'b1;
            tick();
        end
        rd_word = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    logic [15:0] t1w [3];

    initial begin
        t1w[0] = 16'hABCD; t1w[1] = 16'h1234; t1w[2] = 16'hEF56;

        // Reset state
        #12;
        check("rst_din",  rx_din_A, 16'h0000);
        check("rst_busy", rd_busy,  1'b0);
        check("rst_drop", drop_cnt, 8'h00);
        reset = 1'b0;
        tick(); tick();

        // 1: all channels together
        for (int c = 0; c < NCHAN; c++) set_chan(c, 24'hABCDEF, 24'h123456);
        strobe('1);
        check("t1_avail", rx_avail_A, 1'b1);
        check("t1_busy",  rd_busy,    1'b1);
        for (int w = 0; w < NW; w++) begin
            check("t1_word", rx_din_A, t1w[w % 3]);
            check("t1_chan", chan_o, w / 3);
            rd_word = 1'b1;
            tick();
        end
        rd_word = 1'b0;
        check("t1_release", rd_busy, 1'b0);
        check("t1_avail_gone", rx_avail_A, 1'b0);

        // 2: skewed strobes, channel 2 twice
        for (int c = 0; c < NCHAN; c++) set_chan(c, 24'h0A0B0C + c, 24'h1D2E3F - c);
        for (int cy = 0; cy < 10; cy++) begin
            case (cy)
                0: samp_avail = 4'b0001;
                2: begin set_chan(2, 24'hDEAD00, 24'hBEEF00); samp_avail = 4'b0100; end
                4: samp_avail = 4'b0010;
                6: begin set_chan(2, 24'h765432, 24'hFEDCBA); samp_avail = 4'b0100; end
                9: samp_avail = 4'b1000;
                default: samp_avail = '0;
            endcase
            tick();
            samp_avail = '0;
        end
        check("t2_avail", rx_avail_A, 1'b1);
        check("t2_dup",   dup_err,    1'b1);
        do_reads(6);
        check("t2_c2_w0", rx_din_A, 16'h7654);
        do_reads(1);
        check("t2_c2_w1", rx_din_A, 16'hFEDC);
        do_reads(1);
        check("t2_c2_w2", rx_din_A, 16'h32BA);
        do_reads(4);
        pulse_clear();

        // 3: two frames without reads, then drop saturation
        for (int c = 0; c < NCHAN; c++) set_chan(c, 24'h111111 * (c + 1), 24'hF00000 + c);
        strobe('1);
        for (int c = 0; c < NCHAN; c++) set_chan(c, 24'h333333, 24'h444444);
        strobe('1);
        check("t3_ovr",  overrun,  1'b1);
        check("t3_drop", drop_cnt, 8'd1);
        samp_avail = '1;
        for (int k = 0; k < 260; k++) tick();
        samp_avail = '0;
        check("t3_sat", drop_cnt, 8'hFF);
        for (int w = 0; w < NW; w++) begin
            if (w == 0)  check("t3_w0",  rx_din_A, 16'h1111);
            if (w == 1)  check("t3_w1",  rx_din_A, 16'hF000);
            if (w == 2)  check("t3_w2",  rx_din_A, 16'h1100);
            if (w == 3)  check("t3_w3",  rx_din_A, 16'h2222);
            if (w == 11) check("t3_w11", rx_din_A, 16'h4403);
            rd_word = 1'b1;
            tick();
        end
        rd_word = 1'b0;
        pulse_clear();
        check("t3_cleared", drop_cnt, 8'h00);

        // 4: final read coincides with frame completion
        for (int c = 0; c < NCHAN; c++) set_chan(c, 24'h010203 + c, 24'h040506);
        strobe('1);
        do_reads(NW - 1);
        check("t4_last_chan", chan_o, 4'd3);
        for (int c = 0; c < NCHAN; c++) set_chan(c, 24'h5A5A5A, 24'hA5A5A5);
        rd_word = 1'b1;
        samp_avail = '1;
        tick();
        rd_word = 1'b0;
        samp_avail = '0;
        check("t4_avail", rx_avail_A, 1'b1);
        check("t4_busy",  rd_busy,    1'b1);
        check("t4_ovr",   overrun,    1'b0);
        check("t4_drop",  drop_cnt,   8'h00);
        check("t4_word0", rx_din_A,   16'h5A5A);
        do_reads(NW);

        // 5: build up every error, then clear
        strobe(4'b0001);
        strobe(4'b0001);
        strobe(4'b1110);
        strobe('1);
        do_reads(NW);
        rd_word = 1'b1;
        tick();
        rd_word = 1'b0;
        check("t5_und",  underrun, 1'b1);
        check("t5_dup",  dup_err,  1'b1);
        check("t5_ovr",  overrun,  1'b1);
        check("t5_drop", drop_cnt, 8'd1);
        pulse_clear();
        check("t5_clr_und",  underrun, 1'b0);
        check("t5_clr_dup",  dup_err,  1'b0);
        check("t5_clr_ovr",  overrun,  1'b0);
        check("t5_clr_drop", drop_cnt, 8'h00);
        rd_word = 1'b1;
        clear_err = 1'b1;
        tick();
        rd_word = 1'b0;
        clear_err = 1'b0;
        check("t5_event_wins", underrun, 1'b1);
        pulse_clear();

        // 6: asynchronous reset mid-readout
        for (int c = 0; c < NCHAN; c++) set_chan(c, 24'h9ABCDE, 24'h13579B);
        strobe('1);
        do_reads(4);
        check("t6_chan1", chan_o, 4'd1);
        @(posedge adc_clk);
        #3;
        reset = 1'b1;
        #1;
        check("t6_rst_din",  rx_din_A, 16'h0000);
        check("t6_rst_chan", chan_o,   4'd0);
        check("t6_rst_busy", rd_busy,  1'b0);
        check("t6_rst_und",  underrun, 1'b0);
        #2;
        reset = 1'b0;
        tick();
        strobe(4'b0111);
        tick();
        check("t6_no_avail", rx_avail_A, 1'b0);
        strobe(4'b1000);
        check("t6_avail", rx_avail_A, 1'b1);
        check("t6_word0", rx_din_A, 16'h9ABC);
        do_reads(NW);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
